yz_hizlandirici_denetleyici: RTL and testbench

- Issuing side of the dot-product accelerator interface in the X-extension execute path.
- Accepts one decoded X-instruction at a time from the execute stage through a valid/ready handshake.
- Converts it into single-cycle command strobes for the accelerator (load_w, load_x, clr_w, clr_x, run, rs2_enable plus operands). Keeps mirror occupancy counters, checks overflow and length mismatch, and returns the result/error with back-pressure.

---
 rtl/yz_hizlandirici_denetleyici_if.sv | 59 +++++
 rtl/yz_hizlandirici_denetleyici.sv | 167 ++++++++++++++++
 tb/tb_yz_hizlandirici_denetleyici.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/yz_hizlandirici_denetleyici_if.sv
// ============================================================================
// Module   : yz_hizlandirici_denetleyici_if
// Brief    : Request/response handshake and accelerator command bus of the
//            dot-product accelerator issuing controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface yz_hizlandirici_denetleyici_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  req_op_i;
    logic [31:0] req_rs1_i;
    logic [31:0] req_rs2_i;
    logic        req_rs2_en_i;

    logic        load_w_o;
    logic        load_x_o;
    logic        clr_w_o;
    logic        clr_x_o;
    logic        run_o;
    logic        rs2_enable_o;
    logic [31:0] src_reg1_val_o;
    logic [31:0] src_reg2_val_o;
    logic [31:0] dst_reg_val_i;
    logic        w_full_i;
    logic        x_full_i;
    logic        w_empty_i;
    logic        x_empty_i;

    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_data_o;
    logic        resp_err_o;

    // Controller side
    modport slave (
        input  req_valid_i, req_op_i, req_rs1_i, req_rs2_i, req_rs2_en_i,
        input  dst_reg_val_i, w_full_i, x_full_i, w_empty_i, x_empty_i,
        input  resp_ready_i,
        output req_ready_o,
        output load_w_o, load_x_o, clr_w_o, clr_x_o, run_o, rs2_enable_o,
        output src_reg1_val_o, src_reg2_val_o,
        output resp_valid_o, resp_data_o, resp_err_o
    );

    // Execute stage plus accelerator side
    modport master (
        output req_valid_i, req_op_i, req_rs1_i, req_rs2_i, req_rs2_en_i,
        output dst_reg_val_i, w_full_i, x_full_i, w_empty_i, x_empty_i,
        output resp_ready_i,
        input  req_ready_o,
        input  load_w_o, load_x_o, clr_w_o, clr_x_o, run_o, rs2_enable_o,
        input  src_reg1_val_o, src_reg2_val_o,
        input  resp_valid_o, resp_data_o, resp_err_o
    );
endinterface

`default_nettype wire

// File: rtl/yz_hizlandirici_denetleyici.sv
// ============================================================================
// Module   : yz_hizlandirici_denetleyici
// Brief    : Issues one X-instruction at a time to the dot-product accelerator,
//            mirrors buffer occupancy and returns result/error.
//            Optional macro YZ_DURUM_DENETIM_EN: cross-check mirror counters
//            against the accelerator status flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module yz_hizlandirici_denetleyici #(
    parameter int DEPTH       = 16,
    parameter int RUN_LATENCY = 2
) (
    input  wire logic                   clk_i,
    input  wire logic                   rst_ni,
    yz_hizlandirici_denetleyici_if.slave bus
);

    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [3:0]  C_LAT   = 4'(RUN_LATENCY);

    localparam logic [2:0] OP_LD_W  = 3'd0;
    localparam logic [2:0] OP_LD_X  = 3'd1;
    localparam logic [2:0] OP_CLR_W = 3'd2;
    localparam logic [2:0] OP_CLR_X = 3'd3;
    localparam logic [2:0] OP_RUN   = 3'd4;

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        IDLE     = 3'd1,
        ISSUE    = 3'd2,
        WAIT_RUN = 3'd3,
        RESP     = 3'd4
    } state_t;

    state_t      r_state, w_state_nx;
    logic [2:0]  r_op;
    logic [31:0] r_rs1, r_rs2;
    logic        r_rs2_en;
    logic [CW-1:0] r_w_cnt, r_x_cnt;
    logic [3:0]  r_dly;
    logic [31:0] r_resp_data;
    logic        r_resp_err;

    logic [CW:0] w_n, w_w_sum, w_x_sum;
    logic        w_w_ovf, w_x_ovf, w_stat_err, w_issue_err;

    assign w_n     = r_rs2_en ? (CW+1)'(2) : (CW+1)'(1);
    assign w_w_sum = {1'b0, r_w_cnt} + w_n;
    assign w_x_sum = {1'b0, r_x_cnt} + w_n;
    assign w_w_ovf = (w_w_sum > DEPTH_W);
    assign w_x_ovf = (w_x_sum > DEPTH_W);

`ifdef YZ_DURUM_DENETIM_EN
    assign w_stat_err = (bus.w_full_i  != ({1'b0, r_w_cnt} == DEPTH_W)) |
                        (bus.w_empty_i != (r_w_cnt == '0))              |
                        (bus.x_full_i  != ({1'b0, r_x_cnt} == DEPTH_W)) |
                        (bus.x_empty_i != (r_x_cnt == '0));
`else
    assign w_stat_err = 1'b0;
`endif

    always_comb begin
        w_state_nx         = r_state;
        w_issue_err        = 1'b0;
        bus.req_ready_o    = 1'b0;
        bus.load_w_o       = 1'b0;
        bus.load_x_o       = 1'b0;
        bus.clr_w_o        = 1'b0;
        bus.clr_x_o        = 1'b0;
        bus.run_o          = 1'b0;
        bus.rs2_enable_o   = 1'b0;
        bus.src_reg1_val_o = '0;
        bus.src_reg2_val_o = '0;
        case (r_state)
            INIT: begin
                // Accelerator has no reset of its own; clear both buffers once reset lifts
                if (rst_ni) begin
                    bus.clr_w_o = 1'b1;
                    bus.clr_x_o = 1'b1;
                    w_state_nx  = IDLE;
                end
            end
            IDLE: begin
                bus.req_ready_o = 1'b1;
                if (bus.req_valid_i) w_state_nx = ISSUE;
            end
            ISSUE: begin
                bus.src_reg1_val_o = r_rs1;
                bus.src_reg2_val_o = r_rs2;
                w_state_nx         = RESP;
                case (r_op)
                    OP_LD_W: begin
                        bus.rs2_enable_o = r_rs2_en;
                        bus.load_w_o     = ~w_w_ovf;
                        w_issue_err      = w_w_ovf | w_stat_err;
                    end
                    OP_LD_X: begin
                        bus.rs2_enable_o = r_rs2_en;
                        bus.load_x_o     = ~w_x_ovf;
                        w_issue_err      = w_x_ovf | w_stat_err;
                    end
                    OP_CLR_W: bus.clr_w_o = 1'b1;
                    OP_CLR_X: bus.clr_x_o = 1'b1;
                    OP_RUN: begin
                        bus.run_o   = 1'b1;
                        w_issue_err = (r_w_cnt != r_x_cnt) | (r_w_cnt == '0) | w_stat_err;
                        w_state_nx  = WAIT_RUN;
                    end
                    default: w_issue_err = 1'b1;
                endcase
            end
            WAIT_RUN: begin
                if (r_dly == 4'd1) w_state_nx = RESP;
            end
            RESP: begin
                if (bus.resp_ready_i) w_state_nx = IDLE;
            end
            default: w_state_nx = INIT;
        endcase
    end

    assign bus.resp_valid_o = (r_state == RESP);
    assign bus.resp_data_o  = r_resp_data;
    assign bus.resp_err_o   = r_resp_err;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= INIT;
            r_op        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rs2_en    <= 1'b0;
            r_w_cnt     <= '0;
            r_x_cnt     <= '0;
            r_dly       <= '0;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (r_state == IDLE && bus.req_valid_i) begin
                r_op     <= bus.req_op_i;
                r_rs1    <= bus.req_rs1_i;
                r_rs2    <= bus.req_rs2_i;
                r_rs2_en <= bus.req_rs2_en_i;
            end
            if (bus.clr_w_o)       r_w_cnt <= '0;
            else if (bus.load_w_o) r_w_cnt <= w_w_sum[CW-1:0];
            if (bus.clr_x_o)       r_x_cnt <= '0;
            else if (bus.load_x_o) r_x_cnt <= w_x_sum[CW-1:0];
            if (r_state == ISSUE) begin
                r_resp_err  <= w_issue_err;
                r_resp_data <= '0;
                r_dly       <= C_LAT;
            end
            if (r_state == WAIT_RUN) begin
                r_dly <= r_dly - 4'd1;
                if (r_dly == 4'd1) r_resp_data <= bus.dst_reg_val_i;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_yz_hizlandirici_denetleyici.sv
// ============================================================================
// Module   : tb_yz_hizlandirici_denetleyici
// Brief    : Directed self-checking bench for yz_hizlandirici_denetleyici.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_yz_hizlandirici_denetleyici;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    yz_hizlandirici_denetleyici_if bus ();

    yz_hizlandirici_denetleyici #(.DEPTH(16), .RUN_LATENCY(2)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int passed = 0;
    int total  = 0;

    // Small accelerator stand-in: word counts drive the status flags
    int   acc_w = 0;
    int   acc_x = 0;
    logic force_we = 1'b0;
    logic force_we_val = 1'b0;

    always_ff @(posedge clk_i) begin
        if (bus.clr_w_o)       acc_w <= 0;
        else if (bus.load_w_o) acc_w <= acc_w + 1 + int'(bus.rs2_enable_o);
        if (bus.clr_x_o)       acc_x <= 0;
        else if (bus.load_x_o) acc_x <= acc_x + 1 + int'(bus.rs2_enable_o);
    end

    assign bus.w_full_i  = (acc_w == 16);
    assign bus.x_full_i  = (acc_x == 16);
    assign bus.w_empty_i = force_we ? force_we_val : (acc_w == 0);
    assign bus.x_empty_i = (acc_x == 0);

    logic [5:0]  s_strb;  // {load_w, load_x, clr_w, clr_x, run, rs2_enable}
    logic [31:0] s_op1, s_op2, s_data;
    logic        s_err;
    int          s_lat;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        else passed++;
    endtask

    // Drive one instruction from IDLE through to its response handshake
    task automatic issue_op(input logic [2:0] op, input logic [31:0] rs1,
                            input logic [31:0] rs2, input logic en);
        bus.req_valid_i  = 1'b1;
        bus.req_op_i     = op;
        bus.req_rs1_i    = rs1;
        bus.req_rs2_i    = rs2;
        bus.req_rs2_en_i = en;
        tick();
        bus.req_valid_i = 1'b0;
        s_strb = {bus.load_w_o, bus.load_x_o, bus.clr_w_o, bus.clr_x_o, bus.run_o, bus.rs2_enable_o};
        s_op1  = bus.src_reg1_val_o;
        s_op2  = bus.src_reg2_val_o;
        s_lat  = 1;
        while (!bus.resp_valid_o && s_lat < 40) begin
            tick();
            s_lat++;
        end
        s_data = bus.resp_data_o;
        s_err  = bus.resp_err_o;
        bus.resp_ready_i = 1'b1;
        tick();
        bus.resp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        tick(); tick();
        chk("rst_clr", {31'd0, bus.clr_w_o | bus.clr_x_o}, 32'd0);
        chk("rst_ready", {31'd0, bus.req_ready_o}, 32'd0);
        chk("rst_rvalid", {31'd0, bus.resp_valid_o}, 32'd0);
        chk("rst_rdata", bus.resp_data_o, 32'd0);
        rst_ni = 1'b1;
        #1;
        chk("init_clr", {30'd0, bus.clr_w_o, bus.clr_x_o}, 32'd3);
        chk("init_ready", {31'd0, bus.req_ready_o}, 32'd0);
        tick();
        chk("idle_clr", {30'd0, bus.clr_w_o, bus.clr_x_o}, 32'd0);
        chk("idle_ready", {31'd0, bus.req_ready_o}, 32'd1);
        chk("idle_rvalid", {31'd0, bus.resp_valid_o}, 32'd0);
    endtask

    task automatic test_load_fill();
        for (int i = 0; i < 8; i++) begin
            issue_op(3'd0, 32'd3, 32'd5, 1'b1);
            chk("ldw_strb", {26'd0, s_strb}, 32'b100001);
            chk("ldw_op1", s_op1, 32'd3);
            chk("ldw_op2", s_op2, 32'd5);
            chk("ldw_err", {31'd0, s_err}, 32'd0);
            chk("ldw_lat", s_lat, 32'd2);
        end
        issue_op(3'd0, 32'd3, 32'd5, 1'b0);
        chk("ldw_ovf_strb", {26'd0, s_strb}, 32'd0);
        chk("ldw_ovf_err", {31'd0, s_err}, 32'd1);
    endtask

    task automatic test_run_ok();
        issue_op(3'd2, 32'd0, 32'd0, 1'b0);
        chk("clrw_strb", {26'd0, s_strb}, 32'b001000);
        issue_op(3'd3, 32'd0, 32'd0, 1'b0);
        chk("clrx_strb", {26'd0, s_strb}, 32'b000100);
        issue_op(3'd0, 32'd1, 32'd2, 1'b1);
        issue_op(3'd1, 32'd3, 32'd4, 1'b1);
        chk("ldx_strb", {26'd0, s_strb}, 32'b010001);
        issue_op(3'd4, 32'd9, 32'd9, 1'b1);
        chk("run_strb", {26'd0, s_strb}, 32'b000010);
        chk("run_lat", s_lat, 32'd4);
        chk("run_data", s_data, 32'd34);
        chk("run_err", {31'd0, s_err}, 32'd0);
    endtask

    task automatic test_run_mismatch();
        issue_op(3'd2, 32'd0, 32'd0, 1'b0);
        issue_op(3'd3, 32'd0, 32'd0, 1'b0);
        issue_op(3'd0, 32'd1, 32'd2, 1'b1);
        issue_op(3'd1, 32'd3, 32'd0, 1'b0);
        issue_op(3'd4, 32'd0, 32'd0, 1'b0);
        chk("mis_strb", {26'd0, s_strb}, 32'b000010);
        chk("mis_err", {31'd0, s_err}, 32'd1);
        chk("mis_data", s_data, 32'd34);
        issue_op(3'd2, 32'd0, 32'd0, 1'b0);
        issue_op(3'd3, 32'd0, 32'd0, 1'b0);
        issue_op(3'd4, 32'd0, 32'd0, 1'b0);
        chk("empty_run_err", {31'd0, s_err}, 32'd1);
    endtask

    task automatic test_back_pressure();
        logic [31:0] d0;
        logic        e0;
        bus.req_valid_i  = 1'b1;
        bus.req_op_i     = 3'd0;
        bus.req_rs1_i    = 32'd7;
        bus.req_rs2_i    = 32'd0;
        bus.req_rs2_en_i = 1'b0;
        tick();
        bus.req_op_i = 3'd6;
        tick();
        d0 = bus.resp_data_o;
        e0 = bus.resp_err_o;
        chk("bp_first_data", d0, 32'd0);
        chk("bp_first_err", {31'd0, e0}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, bus.resp_valid_o}, 32'd1);
            chk("bp_ready", {31'd0, bus.req_ready_o}, 32'd0);
            chk("bp_data", bus.resp_data_o, d0);
            chk("bp_err", {31'd0, bus.resp_err_o}, {31'd0, e0});
            tick();
        end
        bus.req_valid_i  = 1'b0;
        bus.resp_ready_i = 1'b1;
        tick();
        bus.resp_ready_i = 1'b0;
        chk("bp_released", {31'd0, bus.resp_valid_o}, 32'd0);
        chk("bp_no_accept", {31'd0, bus.req_ready_o}, 32'd1);
    endtask

    task automatic test_reset_in_run();
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = 3'd4;
        tick();
        bus.req_valid_i = 1'b0;
        tick();
        rst_ni = 1'b0;
        tick();
        chk("rr_rvalid", {31'd0, bus.resp_valid_o}, 32'd0);
        chk("rr_strb", {26'd0, bus.load_w_o, bus.load_x_o, bus.clr_w_o, bus.clr_x_o,
                              bus.run_o, bus.rs2_enable_o}, 32'd0);
        rst_ni = 1'b1;
        #1;
        chk("rr_clr", {30'd0, bus.clr_w_o, bus.clr_x_o}, 32'd3);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_no_resp", {31'd0, bus.resp_valid_o}, 32'd0);
        end
        issue_op(3'd0, 32'd1, 32'd1, 1'b1);
        issue_op(3'd1, 32'd1, 32'd1, 1'b1);
        issue_op(3'd4, 32'd0, 32'd0, 1'b0);
        chk("rr_cnt_cleared", {31'd0, s_err}, 32'd0);
    endtask

    task automatic test_illegal();
        issue_op(3'd6, 32'd11, 32'd12, 1'b1);
        chk("ill_strb", {26'd0, s_strb}, 32'd0);
        chk("ill_err", {31'd0, s_err}, 32'd1);
        chk("ill_data", s_data, 32'd0);
        chk("ill_lat", s_lat, 32'd2);
    endtask

`ifdef YZ_DURUM_DENETIM_EN
    task automatic test_status_check();
        issue_op(3'd2, 32'd0, 32'd0, 1'b0);
        issue_op(3'd3, 32'd0, 32'd0, 1'b0);
        force_we     = 1'b1;
        force_we_val = 1'b0;
        issue_op(3'd4, 32'd0, 32'd0, 1'b0);
        chk("st_empty_err", {31'd0, s_err}, 32'd1);
        force_we = 1'b0;
        issue_op(3'd0, 32'd1, 32'd1, 1'b1);
        issue_op(3'd1, 32'd1, 32'd1, 1'b1);
        force_we     = 1'b1;
        force_we_val = 1'b1;
        issue_op(3'd4, 32'd0, 32'd0, 1'b0);
        chk("st_flag_err", {31'd0, s_err}, 32'd1);
        force_we = 1'b0;
        issue_op(3'd4, 32'd0, 32'd0, 1'b0);
        chk("st_ok", {31'd0, s_err}, 32'd0);
    endtask
`endif

    initial begin
        bus.req_valid_i   = 1'b0;
        bus.req_op_i      = '0;
        bus.req_rs1_i     = '0;
        bus.req_rs2_i     = '0;
        bus.req_rs2_en_i  = 1'b0;
        bus.resp_ready_i  = 1'b0;
        bus.dst_reg_val_i = 32'd34;
        test_reset();
        test_load_fill();
        test_run_ok();
        test_run_mismatch();
        test_back_pressure();
        test_reset_in_run();
        test_illegal();
`ifdef YZ_DURUM_DENETIM_EN
        test_status_check();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
